// File: rtl/mat_addr_gen_pkg.sv
// Shared definitions for the matrix address generator.
//   DEF_ADDR_WIDTH : default width of addresses and strides
//   DEF_DIM_WIDTH  : default width of row/col counts and indices
//   state_e        : traversal FSM states
package mat_addr_gen_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DIM_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mat_addr_dim.sv
// One traversal dimension: an index counter plus the address of the current
// position along this dimension. The counter/address pair is loaded at the
// start of a traversal, stepped by one stride, or rewound to index 0 with a
// supplied address.
//   clock, reset_n : clock and asynchronous active-low reset
//   load/load_addr : start of traversal: idx=0, addr=load_addr
//   rewind/rewind_addr : wrap to idx=0 with addr=rewind_addr
//   inc            : idx+1, addr+stride
//   stride, count  : step size and number of positions in this dimension
//   idx, addr      : current index and address
//   at_last        : idx == count-1
module mat_addr_dim
  import mat_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DIM_WIDTH  = DEF_DIM_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  rewind,
  input  logic [ADDR_WIDTH-1:0] rewind_addr,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [DIM_WIDTH-1:0]  count,
  output logic [DIM_WIDTH-1:0]  idx,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  at_last
);

  logic [DIM_WIDTH-1:0]  idx_q,  idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    idx_d  = idx_q;
    addr_d = addr_q;
    if (load) begin
      idx_d  = '0;
      addr_d = load_addr;
    end else if (rewind) begin
      idx_d  = '0;
      addr_d = rewind_addr;
    end else if (inc) begin
      idx_d  = idx_q + DIM_WIDTH'(1);
      addr_d = addr_q + stride;   // modulo 2^ADDR_WIDTH
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      addr_q <= '0;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
    end
  end

  assign idx     = idx_q;
  assign addr    = addr_q;
  assign at_last = (idx_q == (count - DIM_WIDTH'(1)));

endmodule

// File: rtl/mat_addr_gen.sv
// Matrix address generator: walks a rows x cols matrix starting at base,
// emitting one element address per accepted handshake, row-major by default.
// Optional macro MAT_ADDR_GEN_TRANSPOSE_EN adds a 'transpose' input that
// selects column-major order (captured at start).
//   clock, reset_n        : clock, asynchronous active-low reset
//   start, abort          : begin traversal (IDLE only) / cancel traversal
//   rows, cols            : matrix dimensions, captured at start
//   base, row_stride, col_stride : start address and strides, captured at start
//   addr, row_idx, col_idx: current element
//   addr_valid/addr_ready : element handshake
//   last, busy, done      : final element, traversal active, completion pulse
module mat_addr_gen
  import mat_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DIM_WIDTH  = DEF_DIM_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
`ifdef MAT_ADDR_GEN_TRANSPOSE_EN
  input  logic                  transpose,
`endif
  input  logic [DIM_WIDTH-1:0]  rows,
  input  logic [DIM_WIDTH-1:0]  cols,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  input  logic [ADDR_WIDTH-1:0] col_stride,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DIM_WIDTH-1:0]  row_idx,
  output logic [DIM_WIDTH-1:0]  col_idx,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  state_e state_q, state_d;

  // Captured configuration. Base needs no copy of its own: both dimension
  // address registers are loaded with it on the accepted start.
  logic [DIM_WIDTH-1:0]  rows_q, rows_d;
  logic [DIM_WIDTH-1:0]  cols_q, cols_d;
  logic [ADDR_WIDTH-1:0] row_stride_q, row_stride_d;
  logic [ADDR_WIDTH-1:0] col_stride_q, col_stride_d;
  logic                  col_major;

  logic accept, xfer;
  logic in_inc, in_rewind, out_inc;

  logic [DIM_WIDTH-1:0]  in_count,  out_count;
  logic [ADDR_WIDTH-1:0] in_stride, out_stride;
  logic [DIM_WIDTH-1:0]  in_idx,    out_idx;
  logic [ADDR_WIDTH-1:0] in_addr,   out_addr;
  logic                  in_last,   out_last, all_last;

  assign accept   = (state_q == ST_IDLE) && start;
  assign all_last = in_last && out_last;

  // ---------------- configuration capture ----------------
  always_comb begin
    rows_d       = rows_q;
    cols_d       = cols_q;
    row_stride_d = row_stride_q;
    col_stride_d = col_stride_q;
    if (accept) begin
      rows_d       = rows;
      cols_d       = cols;
      row_stride_d = row_stride;
      col_stride_d = col_stride;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rows_q       <= '0;
      cols_q       <= '0;
      row_stride_q <= '0;
      col_stride_q <= '0;
    end else begin
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      row_stride_q <= row_stride_d;
      col_stride_q <= col_stride_d;
    end
  end

`ifdef MAT_ADDR_GEN_TRANSPOSE_EN
  logic transpose_q, transpose_d;

  always_comb begin
    transpose_d = transpose_q;
    if (accept) transpose_d = transpose;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) transpose_q <= 1'b0;
    else          transpose_q <= transpose_d;
  end

  assign col_major = transpose_q;
`else
  assign col_major = 1'b0;
`endif

  // The inner (fast) dimension is columns in row-major order and rows in
  // column-major order; the outer dimension is the other one.
  always_comb begin
    if (col_major) begin
      in_count   = rows_q;
      in_stride  = row_stride_q;
      out_count  = cols_q;
      out_stride = col_stride_q;
      row_idx    = in_idx;
      col_idx    = out_idx;
    end else begin
      in_count   = cols_q;
      in_stride  = col_stride_q;
      out_count  = rows_q;
      out_stride = row_stride_q;
      row_idx    = out_idx;
      col_idx    = in_idx;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((rows == '0) || (cols == '0)) state_d = ST_DONE;
          else                              state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort)                         state_d = ST_IDLE;
        else if (addr_ready && all_last)   state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs and datapath control ----------------
  // An abort during the DONE cycle suppresses that cycle's done pulse.
  // On the final transfer nothing steps; the element registers just hold.
  always_comb begin
    busy       = (state_q == ST_RUN);
    addr_valid = (state_q == ST_RUN);
    last       = (state_q == ST_RUN) && all_last;
    done       = (state_q == ST_DONE) && !abort;
    xfer       = (state_q == ST_RUN) && addr_ready && !abort;
    in_inc     = xfer && !in_last;
    in_rewind  = xfer && in_last && !out_last;
    out_inc    = in_rewind;
  end

  // ---------------- dimension counters ----------------
  // Inner wrap jumps to the next outer position, i.e. the outer start
  // address plus one outer stride.
  mat_addr_dim #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_dim_inner (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (accept),
    .load_addr   (base),
    .rewind      (in_rewind),
    .rewind_addr (out_addr + out_stride),
    .inc         (in_inc),
    .stride      (in_stride),
    .count       (in_count),
    .idx         (in_idx),
    .addr        (in_addr),
    .at_last     (in_last)
  );

  mat_addr_dim #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_dim_outer (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (accept),
    .load_addr   (base),
    .rewind      (1'b0),
    .rewind_addr ('0),
    .inc         (out_inc),
    .stride      (out_stride),
    .count       (out_count),
    .idx         (out_idx),
    .addr        (out_addr),
    .at_last     (out_last)
  );

  assign addr = in_addr;

endmodule

// File: tb/tb_mat_addr_gen.sv
// Directed bench for mat_addr_gen: hand-computed address sequences for
// row-major traversal, stalls, empty matrix, address wrap, abort, reset
// mid-traversal and (when MAT_ADDR_GEN_TRANSPOSE_EN is defined) transpose.
module tb_mat_addr_gen;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [7:0]  rows, cols;
  logic [15:0] base, row_stride, col_stride;
  logic [15:0] addr;
  logic [7:0]  row_idx, col_idx;
  logic        addr_valid, addr_ready, last, busy, done;
`ifdef MAT_ADDR_GEN_TRANSPOSE_EN
  logic        transpose;
`endif

  int unsigned vectors = 0;
  int unsigned misses  = 0;

  always #5 clock = ~clock;

  mat_addr_gen #(
    .ADDR_WIDTH (16),
    .DIM_WIDTH  (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
`ifdef MAT_ADDR_GEN_TRANSPOSE_EN
    .transpose  (transpose),
`endif
    .rows       (rows),
    .cols       (cols),
    .base       (base),
    .row_stride (row_stride),
    .col_stride (col_stride),
    .addr       (addr),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_2x3();
    rows = 8'd2; cols = 8'd3; base = 16'd100; col_stride = 16'd1; row_stride = 16'd10;
  endtask

  initial begin
    logic [15:0] seq [6];
    int unsigned k;
    int unsigned budget;

    seq[0] = 16'd100; seq[1] = 16'd101; seq[2] = 16'd102;
    seq[3] = 16'd110; seq[4] = 16'd111; seq[5] = 16'd112;

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    rows = '0; cols = '0; base = '0; row_stride = '0; col_stride = '0;
`ifdef MAT_ADDR_GEN_TRANSPOSE_EN
    transpose = 1'b0;
`endif

    // ---- reset state ----
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", addr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", last, 0);
    check("rst_addr", addr, 0);
    check("rst_row", row_idx, 0);
    check("rst_col", col_idx, 0);
    reset_n = 1'b1;
    step();

    // ---- 2x3 row-major, ready=1; inputs changed after start; start in RUN ignored ----
    cfg_2x3(); addr_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; rows = 8'd9; cols = 8'd9; base = 16'd500; col_stride = 16'd7;
    for (int i = 0; i < 6; i++) begin
      check("rm_valid", addr_valid, 1);
      check("rm_busy", busy, 1);
      check("rm_addr", addr, seq[i]);
      check("rm_row", row_idx, i / 3);
      check("rm_col", col_idx, i % 3);
      check("rm_last", last, (i == 5));
      start = (i == 2);
      step();
    end
    check("rm_done", done, 1);
    check("rm_done_valid", addr_valid, 0);
    check("rm_done_busy", busy, 0);
    step();
    check("rm_done_pulse", done, 0);
    check("rm_idle_busy", busy, 0);

    // ---- same config, ready pattern 1,0,0,1,0,0... ----
    cfg_2x3(); start = 1'b1;
    step();
    start = 1'b0;
    k = 0; budget = 0;
    while (k < 6 && budget < 40) begin
      addr_ready = ((budget % 3) == 0);
      check("st_valid", addr_valid, 1);
      check("st_addr", addr, seq[k]);
      check("st_row", row_idx, k / 3);
      check("st_col", col_idx, k % 3);
      check("st_last", last, (k == 5));
      step();
      if (addr_ready) k++;
      budget++;
    end
    check("st_count", k, 6);
    check("st_done", done, 1);
    step();
    check("st_done_pulse", done, 0);

    // ---- empty matrix: rows=0 ----
    rows = 8'd0; cols = 8'd5; base = 16'd100; addr_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("z_valid", addr_valid, 0);
    check("z_busy", busy, 0);
    check("z_done", done, 1);
    step();
    check("z_valid2", addr_valid, 0);
    check("z_done2", done, 0);

    // ---- address wrap ----
    rows = 8'd1; cols = 8'd4; base = 16'hFFFE; col_stride = 16'd1; row_stride = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("w_addr0", addr, 16'hFFFE);
    step();
    check("w_addr1", addr, 16'hFFFF);
    step();
    check("w_addr2", addr, 16'h0000);
    check("w_last2", last, 0);
    step();
    check("w_addr3", addr, 16'h0001);
    check("w_last3", last, 1);
    step();
    check("w_done", done, 1);
    step();

    // ---- abort on third element (with ready=1) ----
    cfg_2x3(); start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("ab_addr1", addr, 16'd101);
    step();
    check("ab_addr2", addr, 16'd102);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_valid", addr_valid, 0);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    step();
    check("ab_done2", done, 0);
    check("ab_valid2", addr_valid, 0);
    // abort and start together in IDLE: start wins, restart from base
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("rs_valid", addr_valid, 1);
    check("rs_addr", addr, 16'd100);
    check("rs_row", row_idx, 0);
    check("rs_col", col_idx, 0);
    step();
    check("rs_addr1", addr, 16'd101);

    // ---- reset mid-traversal ----
    reset_n = 1'b0;
    #1;
    check("mr_valid", addr_valid, 0);
    check("mr_addr", addr, 0);
    check("mr_busy", busy, 0);
    step();
    reset_n = 1'b1;
    step();
    check("mr_done", done, 0);
    check("mr_valid2", addr_valid, 0);
    step();
    check("mr_done2", done, 0);

`ifdef MAT_ADDR_GEN_TRANSPOSE_EN
    // ---- column-major ----
    cfg_2x3(); transpose = 1'b1; addr_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; transpose = 1'b0;
    seq[0] = 16'd100; seq[1] = 16'd110; seq[2] = 16'd101;
    seq[3] = 16'd111; seq[4] = 16'd102; seq[5] = 16'd112;
    for (int i = 0; i < 6; i++) begin
      check("tp_valid", addr_valid, 1);
      check("tp_addr", addr, seq[i]);
      check("tp_row", row_idx, i % 2);
      check("tp_col", col_idx, i / 2);
      check("tp_last", last, (i == 5));
      step();
    end
    check("tp_done", done, 1);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/mat_addr_gen.md
MAT_ADDR_GEN -- requirements
Module: mat_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning width of generated address and strides.
REQ-002 SHALL have parameter DIM_WIDTH, default 8, meaning width of row/col counts and indices.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a traversal.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the current traversal.
REQ-007 SHALL have ports rows, cols  input  DIM_WIDTH each  matrix dimensions.
REQ-008 SHALL have ports base, row_stride, col_stride  input  ADDR_WIDTH each  start address and per-dimension increments.
REQ-009 SHALL have port addr  output  ADDR_WIDTH  current element address.
REQ-010 SHALL have ports row_idx, col_idx  output  DIM_WIDTH each  current element indices.
REQ-011 SHALL have ports addr_valid (output, 1) and addr_ready (input, 1), forming the element handshake.
REQ-012 SHALL have ports last, busy, done  output  1 each  final element flag, traversal active, one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; busy=1 exactly in RUN.
REQ-014 SHALL accept start only in IDLE; start in RUN or DONE is ignored.
REQ-015 SHALL capture rows, cols, base and both strides on the accepted start edge; later input changes have no effect until the next start.
REQ-016 SHALL, on accepted start with rows!=0 and cols!=0, enter RUN with addr=base, row_idx=col_idx=0, addr_valid=1 in the next cycle (latency 1).
REQ-017 SHALL, on accepted start with rows==0 or cols==0, enter DONE directly, never assert addr_valid.
REQ-018 SHALL hold addr, row_idx, col_idx, last stable while addr_valid=1 and addr_ready=0.
REQ-019 SHALL advance one element per cycle in which addr_valid and addr_ready are both 1.
REQ-020 SHALL advance row-major: col_idx<cols-1 -> col_idx+1, addr+col_stride; else col_idx=0, row_idx+1, addr = previous row start + row_stride.
REQ-021 SHALL compute all address arithmetic modulo 2^ADDR_WIDTH (silent wrap).
REQ-022 SHALL assert last with addr_valid exactly when row_idx=rows-1 and col_idx=cols-1.
REQ-023 SHALL, on the transfer of the last element, deassert addr_valid and enter DONE next cycle.
REQ-024 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-025 SHALL, on abort in RUN or DONE, enter IDLE next cycle with addr_valid=0 and no done pulse; abort has priority over a simultaneous transfer.
REQ-026 SHALL ignore abort in IDLE; start and abort together in IDLE: start wins.

Reset
REQ-027 SHALL, while reset_n=0, force state IDLE and addr, row_idx, col_idx, addr_valid, last, busy, done and all captured configuration to 0.
REQ-028 SHALL, on reset mid-traversal, discard the traversal; no done pulse after release.

Configuration
REQ-029 SHALL, with macro MAT_ADDR_GEN_TRANSPOSE_EN defined, add input transpose (1 bit, captured at start) selecting column-major order: row_idx advances first using row_stride, then col_idx using col_stride; last still at (rows-1, cols-1).
REQ-030 SHALL, without MAT_ADDR_GEN_TRANSPOSE_EN, omit the transpose port and support row-major only.

Structure
REQ-031 SHALL take the FSM state enum and default ADDR_WIDTH/DIM_WIDTH constants from the shared package.
REQ-032 SHALL use one sub-module, mat_addr_dim: index counter plus dimension-start address register, instantiated once per dimension.

Verification
REQ-033 SHALL check rows=2, cols=3, base=100, col_stride=1, row_stride=10, ready=1 -> addr 100,101,102,110,111,112 on consecutive cycles, last on 112, done one cycle later.
REQ-034 SHALL check same config with ready toggling 1,0,0,1... -> identical address sequence, outputs stable during stalls, no element skipped or repeated.
REQ-035 SHALL check rows=0, cols=5 start -> addr_valid never 1, done one cycle after start is accepted.
REQ-036 SHALL check ADDR_WIDTH=16, base=0xFFFE, rows=1, cols=4, col_stride=1 -> 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-037 SHALL check abort during third element of 2x3 -> addr_valid low next cycle, busy=0, no done; new start then restarts from base.
REQ-038 SHALL check, with MAT_ADDR_GEN_TRANSPOSE_EN and transpose=1, 2x3 config of REQ-033 -> 100,110,101,111,102,112.
